// File: rtl/spwm_gate_sequencer.sv
// spwm_gate_sequencer: start/stop, fault and dead-time controller for a
// three-phase inverter gate stage. Sits between the sine/triangle comparators
// and the six gate pins. Every gate output comes straight from a flop.
//
// Optional feature macro: SPWM_SEQ_BOOT_EN
//   defined   -> bootstrap pre-charge state (BOOT) between IDLE and RUN
//   undefined -> IDLE goes straight to RUN; state never reads 1
module spwm_gate_sequencer #(
  parameter int DT_CYCLES   = 4,   // 1..255
  parameter int BOOT_CYCLES = 64   // 1..65535
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active-low
  input  logic       en,
  input  logic       fault,
  input  logic       fault_clr,
  input  logic       a_cmd,
  input  logic       b_cmd,
  input  logic       c_cmd,
  output logic       Va,
  output logic       Van,
  output logic       Vb,
  output logic       Vbn,
  output logic       Vc,
  output logic       Vcn,
  output logic [1:0] state,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [7:0] DT_LOAD = 8'(DT_CYCLES);

  state_e     state_q, state_d;
  logic       running_q;
  logic [2:0] cmd;
  logic [2:0] hi_all;
  logic [2:0] lo_all;
  logic       run_entry;

  assign cmd       = {c_cmd, b_cmd, a_cmd};
  // Gates are computed from the next state so a state change and its gate
  // pattern appear on the same clock edge.
  assign run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);

`ifdef SPWM_SEQ_BOOT_EN
  logic [15:0] boot_cnt_q;
  logic        boot_done;

  assign boot_done = (boot_cnt_q == 16'(BOOT_CYCLES - 1));

  // Boot counter: counts cycles spent in BOOT, cleared everywhere else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boot_cnt_q <= 16'd0;
    end else if ((state_q == ST_BOOT) && (state_d == ST_BOOT)) begin
      boot_cnt_q <= boot_cnt_q + 16'd1;
    end else begin
      boot_cnt_q <= 16'd0;
    end
  end
`endif

  // Next-state logic: fault beats en = 0, which beats normal progression.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
`ifdef SPWM_SEQ_BOOT_EN
          if (en) state_d = ST_BOOT;
`else
          if (en) state_d = ST_RUN;
`endif
        end
        ST_BOOT: begin
`ifdef SPWM_SEQ_BOOT_EN
          if (!en)            state_d = ST_IDLE;
          else if (boot_done) state_d = ST_RUN;
`else
          state_d = ST_IDLE;
`endif
        end
        ST_RUN: begin
          if (!en) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr && !en) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and status register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_leg
      logic [7:0] dt_cnt_q, dt_cnt_d;
      logic       last_q, last_d;
      logic       hi_q, hi_d;
      logic       lo_q, lo_d;

      // Per-leg dead-time unit: any command change (or RUN entry) blanks both
      // gates for DT_CYCLES cycles before the new side is switched on.
      always_comb begin
        dt_cnt_d = 8'd0;
        last_d   = 1'b0;
        hi_d     = 1'b0;
        lo_d     = 1'b0;
        if (state_d == ST_RUN) begin
          if (run_entry || (cmd[gi] != last_q)) begin
            dt_cnt_d = DT_LOAD;
            last_d   = cmd[gi];
          end else begin
            last_d   = last_q;
            dt_cnt_d = (dt_cnt_q != 8'd0) ? (dt_cnt_q - 8'd1) : 8'd0;
          end
          if (dt_cnt_d == 8'd0) begin
            hi_d = last_d;
            lo_d = ~last_d;
          end
        end else if (state_d == ST_BOOT) begin
          lo_d = 1'b1;
        end
      end

      // Per-leg counter, command memory and gate flops.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dt_cnt_q <= 8'd0;
          last_q   <= 1'b0;
          hi_q     <= 1'b0;
          lo_q     <= 1'b0;
        end else begin
          dt_cnt_q <= dt_cnt_d;
          last_q   <= last_d;
          hi_q     <= hi_d;
          lo_q     <= lo_d;
        end
      end

      assign hi_all[gi] = hi_q;
      assign lo_all[gi] = lo_q;
    end
  endgenerate

  assign Va      = hi_all[0];
  assign Van     = lo_all[0];
  assign Vb      = hi_all[1];
  assign Vbn     = lo_all[1];
  assign Vc      = hi_all[2];
  assign Vcn     = lo_all[2];
  assign state   = state_q;
  assign running = running_q;

endmodule
